// File: rtl/jelly3_jfive_shift_unit.sv
// JFive execute-stage barrel shifter (XLEN 32/64, RV64 word ops); rotate built with JELLY3_JFIVE_SHIFTER_ROTATE_EN.
// Latency: STAGES cycles from accept to m_valid when unstalled, one result per cycle.
// Backpressure: bubble-collapsing stages, s_ready combinational from m_ready, cke=0 freezes everything.
module jelly3_jfive_shift_unit #(
    parameter int XLEN       = 32,
    parameter int SHAMT_BITS = $clog2(XLEN),
    parameter int STAGES     = 2,
    parameter int ID_BITS    = 4,
    parameter int RIDX_BITS  = 6
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  s_arithmetic,
    input  logic                  s_left,
`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
    input  logic                  s_rotate,
`endif
    input  logic                  s_word,
    input  logic                  s_imm_en,
    input  logic [XLEN-1:0]       s_rs1_val,
    input  logic [SHAMT_BITS-1:0] s_rs2_val,
    input  logic [SHAMT_BITS-1:0] s_shamt,
    input  logic [ID_BITS-1:0]    s_id,
    input  logic [RIDX_BITS-1:0]  s_rd_idx,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ID_BITS-1:0]    m_id,
    output logic [RIDX_BITS-1:0]  m_rd_idx,
    output logic [XLEN-1:0]       m_rd_val,
    output logic                  m_valid,
    input  logic                  m_ready
);

`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif
    localparam logic [SHAMT_BITS:0] XLEN_W = (SHAMT_BITS+1)'(XLEN);

    typedef struct packed {
        logic [XLEN-1:0]      val;
        logic [2:0]           fine;
        logic                 left;
        logic                 arith;
        logic                 rot;
        logic                 word;
        logic [ID_BITS-1:0]   id;
        logic [RIDX_BITS-1:0] rd;
    } stage_t;

    // Shifts and rotates compose, so the amount can be split across stages.
    function automatic logic [XLEN-1:0] shift_by(
        input logic [XLEN-1:0]       val,
        input logic [SHAMT_BITS-1:0] amt,
        input logic                  left,
        input logic                  arith,
        input logic                  rot,
        input logic                  word
    );
        logic signed [XLEN-1:0] sval;
        logic [31:0]            w;
        logic [4:0]             a5;
        logic [XLEN-1:0]        r;
        sval = val;
        sval = sval >>> amt;
        w    = val[31:0];
        a5   = amt[4:0];
        if (left)
            r = val << amt;
        else if (arith)
            r = sval;
        else
            r = val >> amt;
        if (ROT_EN && rot) begin
            if (word) begin
                r = '0;
                r[31:0] = left ? ((w << a5) | (w >> (6'd32 - {1'b0, a5})))
                               : ((w >> a5) | (w << (6'd32 - {1'b0, a5})));
            end else begin
                r = left ? ((val << amt) | (val >> (XLEN_W - {1'b0, amt})))
                         : ((val >> amt) | (val << (XLEN_W - {1'b0, amt})));
            end
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] val, input logic word);
        logic [XLEN-1:0] r;
        r = val;
        if (word) begin
            r = {XLEN{val[31]}};
            r[31:0] = val[31:0];
        end
        return r;
    endfunction

    logic                  rot_in;
    logic                  word_in;
    logic [SHAMT_BITS-1:0] sh;
    logic [SHAMT_BITS-1:0] coarse;
    logic [SHAMT_BITS-1:0] fine1;
    logic [XLEN-1:0]       op;
    logic [STAGES-1:0]     vld;
    logic [STAGES:0]       vcat;
    logic [STAGES-1:0]     vin;
    logic [STAGES-1:0]     load;
    stage_t                st  [STAGES];
    stage_t                nxt [STAGES];

`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
    assign rot_in = s_rotate;
`else
    assign rot_in = 1'b0;
`endif

    // Word ops pre-extend the operand so a 64-bit right shift yields the 32-bit answer.
    always_comb begin
        word_in = (XLEN == 64) ? s_word : 1'b0;
        sh      = s_imm_en ? s_shamt : s_rs2_val;
        if (word_in)
            sh[SHAMT_BITS-1] = 1'b0;
        op = s_rs1_val;
        if (word_in) begin
            op = {XLEN{s_arithmetic & s_rs1_val[31]}};
            op[31:0] = s_rs1_val[31:0];
        end
        coarse = {sh[SHAMT_BITS-1:3], 3'b000};
        fine1  = {{(SHAMT_BITS-3){1'b0}}, st[0].fine};
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++)
            nxt[k] = st[k];
        nxt[0].left  = s_left;
        nxt[0].arith = s_arithmetic;
        nxt[0].rot   = rot_in;
        nxt[0].word  = word_in;
        nxt[0].id    = s_id;
        nxt[0].rd    = s_rd_idx;
        nxt[0].val   = shift_by(op, coarse, s_left, s_arithmetic, rot_in, word_in);
        nxt[0].fine  = sh[2:0];
        if (STAGES == 1) begin
            nxt[0].val  = word_fix(shift_by(nxt[0].val, {{(SHAMT_BITS-3){1'b0}}, sh[2:0]},
                                            s_left, s_arithmetic, rot_in, word_in), word_in);
            nxt[0].fine = 3'd0;
        end
        for (int k = 1; k < STAGES; k++) begin
            nxt[k] = st[k-1];
            if (k == 1) begin
                nxt[k].val  = shift_by(st[0].val, fine1, st[0].left, st[0].arith, st[0].rot, st[0].word);
                nxt[k].fine = 3'd0;
                if (STAGES == 2)
                    nxt[k].val = word_fix(nxt[k].val, st[0].word);
            end else begin
                nxt[k].val = word_fix(st[k-1].val, st[k-1].word);
            end
        end
    end

    // A stage loads when some stage at or after it is empty, or the output pops.
    always_comb begin
        logic all_full;
        vcat = {vld, s_valid};
        vin  = vcat[STAGES-1:0];
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            all_full = 1'b1;
            for (int j = k; j < STAGES; j++)
                all_full = all_full & vld[j];
            load[k] = cke & (~all_full | m_ready);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++)
                st[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= vin[k];
                    if (vin[k])
                        st[k] <= nxt[k];
                end
            end
        end
    end

    assign s_ready  = load[0];
    assign m_valid  = vld[STAGES-1];
    assign m_id     = st[STAGES-1].id;
    assign m_rd_idx = st[STAGES-1].rd;
    assign m_rd_val = st[STAGES-1].val;

endmodule

// File: tb/tb_jelly3_jfive_shift_unit.sv
// Bench for jelly3_jfive_shift_unit: a 32-bit and a 64-bit instance share one stimulus stream,
// each checked every cycle against a whole-operation reference model and a few literal results.
module tb_jelly3_jfive_shift_unit;
    localparam int STG = 2;

    logic        clk = 1'b0;
    logic        rst_n, cke, arith, left, rot, word, imm, sv, mr;
    logic [63:0] rs1;
    logic [5:0]  rs2, shamt, rd;
    logic [3:0]  id;

    logic        srdy32, mv32, srdy64, mv64;
    logic [3:0]  mid32, mid64;
    logic [5:0]  mrd32, mrd64;
    logic [31:0] mval32;
    logic [63:0] mval64;

    typedef struct {
        logic [3:0]  id;
        logic [5:0]  rd;
        logic [63:0] val;
    } exp_t;
    exp_t q32[$];
    exp_t q64[$];
    int   pop_ids[$];
    int   checks = 0;
    int   fails = 0;
    int   n_acc = 0;
    bit   rand_mode = 1'b0;

    always #5 clk = ~clk;

    jelly3_jfive_shift_unit #(.XLEN(32), .STAGES(STG)) u32 (
        .reset(rst_n), .clk(clk), .cke(cke), .s_arithmetic(arith), .s_left(left),
`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
        .s_rotate(rot),
`endif
        .s_word(word), .s_imm_en(imm), .s_rs1_val(rs1[31:0]), .s_rs2_val(rs2[4:0]),
        .s_shamt(shamt[4:0]), .s_id(id), .s_rd_idx(rd), .s_valid(sv), .s_ready(srdy32),
        .m_id(mid32), .m_rd_idx(mrd32), .m_rd_val(mval32), .m_valid(mv32), .m_ready(mr)
    );

    jelly3_jfive_shift_unit #(.XLEN(64), .STAGES(STG)) u64 (
        .reset(rst_n), .clk(clk), .cke(cke), .s_arithmetic(arith), .s_left(left),
`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
        .s_rotate(rot),
`endif
        .s_word(word), .s_imm_en(imm), .s_rs1_val(rs1), .s_rs2_val(rs2),
        .s_shamt(shamt), .s_id(id), .s_rd_idx(rd), .s_valid(sv), .s_ready(srdy64),
        .m_id(mid64), .m_rd_idx(mrd64), .m_rd_val(mval64), .m_valid(mv64), .m_ready(mr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Whole result from the ISA rules: 32-bit math for XLEN=32 or word ops, doubled-operand rotates.
    function automatic logic [63:0] model(input bit is32, input logic [63:0] a, input logic [5:0] sh,
                                          input bit lf, input bit ar, input bit wd, input bit rt);
        logic [31:0]         x, r32;
        logic signed [31:0]  xs;
        logic [63:0]         d, y;
        logic signed [63:0]  ys;
        logic [127:0]        dd;
        logic [4:0]          s5;
        if (is32 || wd) begin
            x  = a[31:0];
            s5 = sh[4:0];
            d  = {x, x};
            xs = x;
            if (rt)      r32 = lf ? d[63-s5 -: 32] : d[s5 +: 32];
            else if (lf) r32 = x << s5;
            else if (ar) r32 = xs >>> s5;
            else         r32 = x >> s5;
            return is32 ? {32'h0, r32} : {{32{r32[31]}}, r32};
        end
        y  = a;
        ys = a;
        dd = {a, a};
        if (rt)      y = lf ? dd[127-sh -: 64] : dd[sh +: 64];
        else if (lf) y = a << sh;
        else if (ar) y = ys >>> sh;
        else         y = a >> sh;
        return y;
    endfunction

    // Output checker and scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        exp_t e;
        logic [5:0] sh_now;
        if (!rst_n) begin
            q32.delete();
            q64.delete();
            chk("rst_valid32", {63'h0, mv32}, 64'h0);
            chk("rst_valid64", {63'h0, mv64}, 64'h0);
            chk("rst_id64", {60'h0, mid64}, 64'h0);
            chk("rst_val64", mval64, 64'h0);
        end else begin
            if (q32.size() == 0) chk("extra_result32", {63'h0, mv32}, 64'h0);
            else if (mv32) begin
                chk("id32", {60'h0, mid32}, {60'h0, q32[0].id});
                chk("rd32", {58'h0, mrd32}, {58'h0, q32[0].rd});
                chk("val32", {32'h0, mval32}, q32[0].val);
                if (mr && cke) begin
                    pop_ids.push_back(int'(mid32));
                    void'(q32.pop_front());
                end
            end
            if (q64.size() == 0) chk("extra_result64", {63'h0, mv64}, 64'h0);
            else if (mv64) begin
                chk("id64", {60'h0, mid64}, {60'h0, q64[0].id});
                chk("rd64", {58'h0, mrd64}, {58'h0, q64[0].rd});
                chk("val64", mval64, q64[0].val);
                if (mr && cke) void'(q64.pop_front());
            end
            sh_now = imm ? shamt : rs2;
            e.id = id;
            e.rd = rd;
            if (sv && srdy32 && cke) begin
                e.val = model(1'b1, rs1, sh_now, left, arith, word, rot);
                q32.push_back(e);
            end
            if (sv && srdy64 && cke) begin
                e.val = model(1'b0, rs1, sh_now, left, arith, word, rot);
                q64.push_back(e);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) begin
            cke = ($urandom_range(0, 3) != 0);
            mr  = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [63:0] a, input logic [5:0] s, input bit im, input bit lf,
                        input bit ar, input bit wd, input bit rt, input logic [3:0] i);
        int n;
        bit acc;
        rs1 = a; imm = im; left = lf; arith = ar; word = wd; rot = rt; id = i;
        rd  = 6'($urandom);
        if (im) begin shamt = s; rs2 = 6'($urandom); end
        else    begin rs2 = s;   shamt = 6'($urandom); end
        sv = 1'b1;
        n  = 0;
        while (1) begin
            @(negedge clk);
            acc = srdy32 && cke;
            @(posedge clk);
            #1;
            if (acc) begin n_acc++; break; end
            n++;
            if (n > 300) begin
                checks++; fails++;
                $display("FAIL accept_timeout id=%0d waited=%0d required=accept", i, n);
                break;
            end
        end
        sv = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain32", 64'(q32.size()), 64'h0);
        chk("drain64", 64'(q64.size()), 64'h0);
    endtask

    initial begin
        bit done;
        int n;
        rst_n = 1'b0; cke = 1'b1; mr = 1'b1; sv = 1'b0; rot = 1'b0;
        arith = 1'b0; left = 1'b0; word = 1'b0; imm = 1'b0;
        rs1 = '0; rs2 = '0; shamt = '0; id = '0; rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sready_state", {63'h0, mv32}, 64'h0);
        rst_n = 1'b1;

        // SRA latency and value.
        send(64'h0000_0000_8000_0010, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        chk("lat_cycle1_valid", {63'h0, mv32}, 64'h0);
        @(posedge clk); #1;
        chk("lat_cycle2_valid", {63'h0, mv32}, 64'h1);
        chk("sra32_lit", {32'h0, mval32}, 64'h0000_0000_F800_0001);
        chk("sra64_lit", mval64, 64'h0000_0000_0800_0001);

        // SRAW with shamt=33 (bit 5 dropped), via immediate.
        send(64'h0000_0000_8000_0000, 6'd33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        @(posedge clk); #1;
        chk("sraw64_lit", mval64, 64'hFFFF_FFFF_C000_0000);
        chk("sra32_sh1_lit", {32'h0, mval32}, 64'h0000_0000_C000_0000);

        // SLLW by 31.
        send(64'h1, 6'd31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        @(posedge clk); #1;
        chk("sllw64_lit", mval64, 64'hFFFF_FFFF_8000_0000);
        chk("sll32_lit", {32'h0, mval32}, 64'h0000_0000_8000_0000);

        // sh=0 passes the operand through.
        send(64'hDEAD_BEEF_1234_5678, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        @(posedge clk); #1;
        chk("sh0_64_lit", mval64, 64'hDEAD_BEEF_1234_5678);
        chk("sh0_32_lit", {32'h0, mval32}, 64'h0000_0000_1234_5678);

`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
        send(64'h1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        @(posedge clk); #1;
        chk("ror32_lit", {32'h0, mval32}, 64'h0000_0000_8000_0000);
        chk("ror64_lit", mval64, 64'h8000_0000_0000_0000);
        send(64'h0000_0000_8000_0001, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
        @(posedge clk); #1;
        chk("rol32_lit", {32'h0, mval32}, 64'h0000_0000_0000_0018);
        chk("rol64_lit", mval64, 64'h0000_0008_0000_0010);
`endif
        drain();

        // Back-pressure: 8 back-to-back requests against a stalled output.
        mr = 1'b0;
        n_acc = 0;
        pop_ids.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send({$urandom, $urandom}, 6'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom), 1'b0, 4'(i));
                done = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_entries_held", 64'(n_acc), 64'(STG));
        chk("bp_sready_low", {63'h0, srdy32}, 64'h0);
        @(posedge clk); #1;
        mr = 1'b1;
        n = 0;
        while (!done && n < 400) begin @(posedge clk); n++; end
        drain();
        chk("bp_count", 64'(pop_ids.size()), 64'd8);
        for (int i = 0; i < 8 && i < pop_ids.size(); i++)
            chk("bp_order", 64'(pop_ids[i]), 64'(i));

        // Reset with two results in flight.
        mr = 1'b0;
        send(64'h0123_4567_89AB_CDEF, 6'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        send(64'hFEDC_BA98_7654_3210, 6'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid32", {63'h0, mv32}, 64'h0);
        chk("rst_async_valid64", {63'h0, mv64}, 64'h0);
        chk("rst_async_val64", mval64, 64'h0);
        mr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(64'h0000_0000_0000_00F0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
        @(posedge clk); #1;
        chk("post_rst_id32", {60'h0, mid32}, 64'd9);
        chk("post_rst_id64", {60'h0, mid64}, 64'd9);
        chk("post_rst_val64", mval64, 64'h0000_0000_0000_000F);
        drain();

        // Random cke/m_ready with random ops, including the sh extremes.
        rand_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [5:0] s;
            bit rt;
            case ($urandom_range(0, 3))
                0:       s = 6'd0;
                1:       s = 6'd63;
                2:       s = 6'd31;
                default: s = 6'($urandom);
            endcase
`ifdef JELLY3_JFIVE_SHIFTER_ROTATE_EN
            rt = 1'($urandom);
`else
            rt = 1'b0;
`endif
            send({$urandom, $urandom}, s, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), rt, 4'(i));
            if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        cke = 1'b1;
        mr  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
